snow64_long_div_param_radix: RTL and testbench

Parametrised multi-cycle long divider producing quotient and remainder. It extends the fixed u16-by-u8 radix-8 divider with generic operand widths, a configurable radix, a per-command signed/unsigned mode, a remainder output and an explicit divide-by-zero flag. It serves as the shared iterative divide unit for integer and fixed-point datapaths in the Snow64 execute stage.

---
 rtl/snow64_long_div_param_radix.sv | 185 ++++++++++++++++++
 tb/tb_snow64_long_div_param_radix.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snow64_long_div_param_radix.sv
`default_nettype none
// ============================================================================
// Module   : snow64_long_div_param_radix
// Brief    : Parametrised multi-cycle long divider (quotient + remainder).
//            Retires LOG2_RADIX quotient bits per cycle from a registered
//            multiples table, with signed/unsigned mode and a divide-by-zero
//            flag. Fixed latency of NUM_ITERS+1 cycles from the accept edge.
// Revision : 1.0 - initial release
// ============================================================================
module snow64_long_div_param_radix #(
  parameter int WIDTH_A    = 16,
  parameter int WIDTH_B    = 8,
  parameter int LOG2_RADIX = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_start,
  input  logic               in_signed,
  input  logic [WIDTH_A-1:0] in_a,
  input  logic [WIDTH_B-1:0] in_b,
  output logic               out_can_accept_cmd,
  output logic               out_data_valid,
  output logic [WIDTH_A-1:0] out_quot,
  output logic [WIDTH_B-1:0] out_rem,
  output logic               out_div_by_zero
);

  localparam int RADIX     = 1 << LOG2_RADIX;
  localparam int NUM_ITERS = (WIDTH_A + LOG2_RADIX - 1) / LOG2_RADIX;
  localparam int EXT_W     = NUM_ITERS * LOG2_RADIX;
  localparam int PR_W      = WIDTH_B + LOG2_RADIX;
  localparam int CNT_W     = $clog2(NUM_ITERS + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NUM_ITERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WORK  = 2'd1,
    ST_FIXUP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   accept;

  // Captured command context
  logic [CNT_W-1:0]      cnt;
  logic [EXT_W-1:0]      dividend_sh;   // remaining dividend chunks, MSB-first
  logic [WIDTH_A-1:0]    quot_mag;      // quotient magnitude being assembled
  logic [WIDTH_B-1:0]    pr;            // partial remainder, always < |b|
  logic                  q_neg;
  logic                  r_neg;
  logic                  zero_div;
  logic [PR_W-1:0]       mult_tbl [RADIX];

  // Operand magnitudes at the command boundary
  logic                  a_neg;
  logic                  b_neg;
  logic [WIDTH_A-1:0]    a_mag;
  logic [WIDTH_B-1:0]    b_mag;
  logic [PR_W-1:0]       b_ext;

  // Iteration datapath
  logic [LOG2_RADIX-1:0] chunk;
  logic [PR_W-1:0]       pr_cat;
  logic [LOG2_RADIX-1:0] digit;
  logic [WIDTH_B-1:0]    pr_next;

  // Final sign-corrected results
  logic [WIDTH_A-1:0]    quot_fix;
  logic [WIDTH_B-1:0]    rem_fix;

  assign a_neg = in_signed & in_a[WIDTH_A-1];
  assign b_neg = in_signed & in_b[WIDTH_B-1];
  assign a_mag = a_neg ? -in_a : in_a;
  // |most-negative b| is 2**(WIDTH_B-1), which still fits unsigned
  assign b_mag = b_neg ? -in_b : in_b;
  assign b_ext = PR_W'(b_mag);

  assign chunk  = dividend_sh[EXT_W-1 -: LOG2_RADIX];
  assign pr_cat = {pr, chunk};

  // Quotient digit: largest k whose multiple does not exceed the partial remainder
  always_comb begin
    digit = '0;
    for (int k = 1; k < RADIX; k++) begin
      if (mult_tbl[k] <= pr_cat) begin
        digit = LOG2_RADIX'(k);
      end
    end
  end

  // The true difference is < |b|, so the low WIDTH_B bits are exact
  assign pr_next = pr_cat[WIDTH_B-1:0] - mult_tbl[digit][WIDTH_B-1:0];

  assign quot_fix = zero_div ? '1 : (q_neg ? -quot_mag : quot_mag);
  assign rem_fix  = zero_div ? '0 : (r_neg ? -pr : pr);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and accept decode
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_start) begin
          accept     = 1'b1;
          state_next = ST_WORK;
        end
      end
      ST_WORK: begin
        if (cnt == LAST_ITER) begin
          state_next = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Command capture on accept, then one radix digit per WORK cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      dividend_sh <= '0;
      quot_mag    <= '0;
      pr          <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      zero_div    <= 1'b0;
      for (int k = 0; k < RADIX; k++) begin
        mult_tbl[k] <= '0;
      end
    end else if (accept) begin
      cnt         <= '0;
      dividend_sh <= EXT_W'(a_mag);
      quot_mag    <= '0;
      pr          <= '0;
      q_neg       <= a_neg ^ b_neg;
      r_neg       <= a_neg;
      zero_div    <= (in_b == '0);
      for (int k = 0; k < RADIX; k++) begin
        mult_tbl[k] <= PR_W'(k) * b_ext;
      end
    end else if (state == ST_WORK) begin
      cnt         <= cnt + CNT_W'(1);
      dividend_sh <= dividend_sh << LOG2_RADIX;
      quot_mag    <= (quot_mag << LOG2_RADIX) | WIDTH_A'(digit);
      pr          <= pr_next;
    end
  end

  // Result registers: cleared valid on accept, published in FIXUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_can_accept_cmd <= 1'b1;
      out_data_valid     <= 1'b0;
      out_quot           <= '0;
      out_rem            <= '0;
      out_div_by_zero    <= 1'b0;
    end else if (accept) begin
      out_can_accept_cmd <= 1'b0;
      out_data_valid     <= 1'b0;
    end else if (state == ST_FIXUP) begin
      out_can_accept_cmd <= 1'b1;
      out_data_valid     <= 1'b1;
      out_quot           <= quot_fix;
      out_rem            <= rem_fix;
      out_div_by_zero    <= zero_div;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snow64_long_div_param_radix.sv
`default_nettype none
// ============================================================================
// Module   : tb_snow64_long_div_param_radix
// Brief    : Self-checking bench for the parametrised long divider: default
//            16/8/radix-8 instance plus a 32/16/radix-4 variant, each with
//            an arithmetic reference model and a per-cycle compare process.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snow64_long_div_param_radix;

  localparam int N_DEF = 6;   // ceil(16/3)
  localparam int N_VAR = 16;  // ceil(32/2)

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Free-running cycle count for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  // Default instance
  logic        d_start = 1'b0, d_signed = 1'b0;
  logic [15:0] d_a = '0;
  logic [7:0]  d_b = '0;
  logic        d_can, d_valid, d_dbz;
  logic [15:0] d_quot;
  logic [7:0]  d_rem;

  snow64_long_div_param_radix #(.WIDTH_A(16), .WIDTH_B(8), .LOG2_RADIX(3)) u_def (
    .clk(clk), .rst_n(rst_n), .in_start(d_start), .in_signed(d_signed),
    .in_a(d_a), .in_b(d_b), .out_can_accept_cmd(d_can), .out_data_valid(d_valid),
    .out_quot(d_quot), .out_rem(d_rem), .out_div_by_zero(d_dbz)
  );

  // Variant instance
  logic        v_start = 1'b0, v_signed = 1'b0;
  logic [31:0] v_a = '0;
  logic [15:0] v_b = '0;
  logic        v_can, v_valid, v_dbz;
  logic [31:0] v_quot;
  logic [15:0] v_rem;

  snow64_long_div_param_radix #(.WIDTH_A(32), .WIDTH_B(16), .LOG2_RADIX(2)) u_var (
    .clk(clk), .rst_n(rst_n), .in_start(v_start), .in_signed(v_signed),
    .in_a(v_a), .in_b(v_b), .out_can_accept_cmd(v_can), .out_data_valid(v_valid),
    .out_quot(v_quot), .out_rem(v_rem), .out_div_by_zero(v_dbz)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference results {div_by_zero, quot, rem} from plain integer division
  function automatic logic [24:0] ref_def(input logic s, input logic [15:0] aa, input logic [7:0] bb);
    int na, nb, q, r;
    if (bb == 8'd0) return {1'b1, 16'hFFFF, 8'h00};
    na = s ? int'($signed(aa)) : int'(aa);
    nb = s ? int'($signed(bb)) : int'(bb);
    q  = na / nb;
    r  = na % nb;
    return {1'b0, q[15:0], r[7:0]};
  endfunction

  function automatic logic [48:0] ref_var(input logic s, input logic [31:0] aa, input logic [15:0] bb);
    longint na, nb, q, r;
    if (bb == 16'd0) return {1'b1, 32'hFFFF_FFFF, 16'h0000};
    na = s ? longint'($signed(aa)) : longint'(aa);
    nb = s ? longint'($signed(bb)) : longint'(bb);
    q  = na / nb;
    r  = na % nb;
    return {1'b0, q[31:0], r[15:0]};
  endfunction

  // Transaction-level model: busy window after accept, result due at its end
  int          md_busy = 0;
  logic        md_valid = 1'b0;
  logic [24:0] md_pend = '0, md_exp = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_busy <= 0; md_valid <= 1'b0; md_exp <= '0;
    end else if (d_start && md_busy == 0) begin
      md_pend <= ref_def(d_signed, d_a, d_b); md_busy <= N_DEF + 1; md_valid <= 1'b0;
    end else if (md_busy > 0) begin
      md_busy <= md_busy - 1;
      if (md_busy == 1) begin md_valid <= 1'b1; md_exp <= md_pend; end
    end
  end

  int          mv_busy = 0;
  logic        mv_valid = 1'b0;
  logic [48:0] mv_pend = '0, mv_exp = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_busy <= 0; mv_valid <= 1'b0; mv_exp <= '0;
    end else if (v_start && mv_busy == 0) begin
      mv_pend <= ref_var(v_signed, v_a, v_b); mv_busy <= N_VAR + 1; mv_valid <= 1'b0;
    end else if (mv_busy > 0) begin
      mv_busy <= mv_busy - 1;
      if (mv_busy == 1) begin mv_valid <= 1'b1; mv_exp <= mv_pend; end
    end
  end

  // Per-cycle compare of both instances against the model
  always @(negedge clk) begin
    chk("d_can_accept", d_can, md_busy == 0);
    chk("d_valid", d_valid, md_valid);
    if (md_valid) begin
      chk("d_quot", d_quot, md_exp[23:8]);
      chk("d_rem", d_rem, md_exp[7:0]);
      chk("d_dbz", d_dbz, md_exp[24]);
    end
    chk("v_can_accept", v_can, mv_busy == 0);
    chk("v_valid", v_valid, mv_valid);
    if (mv_valid) begin
      chk("v_quot", v_quot, mv_exp[47:16]);
      chk("v_rem", v_rem, mv_exp[15:0]);
      chk("v_dbz", v_dbz, mv_exp[48]);
    end
  end

  task automatic issue_d(input logic s, input logic [15:0] aa, input logic [7:0] bb, output int tacc);
    @(posedge clk); #1;
    d_start = 1'b1; d_signed = s; d_a = aa; d_b = bb;
    @(posedge clk); #1;
    d_start = 1'b0; tacc = cyc;
  endtask

  task automatic wait_d(output int t);
    t = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (d_valid === 1'b1) begin t = cyc; break; end
    end
    if (t < 0) begin
      n_vec++; n_bad++;
      $display("FAIL d_timeout: valid absent after 40 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic run_d(input string nm, input logic s, input logic [15:0] aa, input logic [7:0] bb,
                       input logic [15:0] eq, input logic [7:0] er, input logic ez);
    int ta, tv;
    issue_d(s, aa, bb, ta);
    wait_d(tv);
    chk({nm, "_latency"}, 64'(tv - ta), 64'(N_DEF + 1));
    chk({nm, "_quot"}, d_quot, eq);
    chk({nm, "_rem"}, d_rem, er);
    chk({nm, "_dbz"}, d_dbz, ez);
  endtask

  task automatic issue_v(input logic s, input logic [31:0] aa, input logic [15:0] bb, output int tacc);
    @(posedge clk); #1;
    v_start = 1'b1; v_signed = s; v_a = aa; v_b = bb;
    @(posedge clk); #1;
    v_start = 1'b0; tacc = cyc;
  endtask

  task automatic wait_v(output int t);
    t = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (v_valid === 1'b1) begin t = cyc; break; end
    end
    if (t < 0) begin
      n_vec++; n_bad++;
      $display("FAIL v_timeout: valid absent after 60 cycles (cycle %0d)", cyc);
    end
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ta, tv;
    logic s;
    logic [15:0] ra;
    logic [7:0]  rb;
    logic [31:0] wa;
    logic [15:0] wb;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_can_accept", d_can, 1);
    chk("rst_valid", d_valid, 0);
    chk("rst_quot", d_quot, 0);
    chk("rst_rem", d_rem, 0);
    chk("rst_dbz", d_dbz, 0);
    chk("rst_v_can_accept", v_can, 1);
    rst_n = 1'b1;

    // Unsigned basic, with busy window
    issue_d(1'b0, 16'd1000, 8'd7, ta);
    chk("t1_busy", d_can, 0);
    wait_d(tv);
    chk("t1_latency", 64'(tv - ta), 7);
    chk("t1_quot", d_quot, 142);
    chk("t1_rem", d_rem, 6);
    chk("t1_dbz", d_dbz, 0);

    // Max operands, then back-to-back start
    run_d("t2a", 1'b0, 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0);
    issue_d(1'b0, 16'h0000, 8'h01, ta);
    chk("t2b_valid_drop", d_valid, 0);
    wait_d(tv);
    chk("t2b_latency", 64'(tv - ta), 7);
    chk("t2b_quot", d_quot, 0);
    chk("t2b_rem", d_rem, 0);

    // Divide by zero in both modes
    run_d("t3u", 1'b0, 16'd1234, 8'd0, 16'hFFFF, 8'h00, 1'b1);
    run_d("t3s", 1'b1, 16'd1234, 8'd0, 16'hFFFF, 8'h00, 1'b1);

    // Signed cases including overflow
    run_d("t4a", 1'b1, 16'hFC18, 8'd7,  16'hFF72, 8'hFA, 1'b0);
    run_d("t4b", 1'b1, 16'd1000, 8'hF9, 16'hFF72, 8'h06, 1'b0);
    run_d("t4c", 1'b1, 16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0);
    run_d("t4d", 1'b1, 16'h8000, 8'h80, 16'h0100, 8'h00, 1'b0);

    // Starts while busy are ignored
    @(posedge clk); #1;
    d_start = 1'b1; d_signed = 1'b0; d_a = 16'd1000; d_b = 8'd7;
    @(posedge clk); #1;
    ta = cyc;
    for (int i = 1; i <= N_DEF + 1; i++) begin
      d_a = 16'($urandom); d_b = 8'($urandom); d_signed = 1'($urandom);
      @(posedge clk); #1;
    end
    d_start = 1'b0;
    wait_d(tv);
    chk("t5_latency", 64'(tv - ta), 7);
    chk("t5_quot", d_quot, 142);
    chk("t5_rem", d_rem, 6);

    // Reset in the middle of WORK aborts the command
    issue_d(1'b0, 16'd999, 8'd5, ta);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_abort_can_accept", d_can, 1);
    chk("t5_abort_valid", d_valid, 0);
    chk("t5_abort_quot", d_quot, 0);
    chk("t5_abort_rem", d_rem, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_d("t5c", 1'b0, 16'd50, 8'd3, 16'd16, 8'd2, 1'b0);

    // Mixed-mode sweep checked by the model each cycle
    for (int i = 0; i < 150; i++) begin
      s  = 1'($urandom);
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      issue_d(s, ra, rb, ta);
      wait_d(tv);
    end

    // Variant configuration
    issue_v(1'b0, 32'd100000, 16'd300, ta);
    wait_v(tv);
    chk("t6_latency", 64'(tv - ta), 17);
    chk("t6_quot", v_quot, 333);
    chk("t6_rem", v_rem, 100);
    chk("t6_dbz", v_dbz, 0);
    issue_v(1'b1, 32'h8000_0000, 16'hFFFF, ta);
    wait_v(tv);
    chk("t6_ovf_quot", v_quot, 32'h8000_0000);
    chk("t6_ovf_rem", v_rem, 0);
    for (int i = 0; i < 60; i++) begin
      s  = 1'($urandom);
      wa = $urandom;
      wb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      issue_v(s, wa, wb, ta);
      wait_v(tv);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
